radix4_mul16: RTL and testbench
===============================

Name: radix4_mul16

Overview:
- Unsigned 16x16 -> 32-bit multiplier for the MiniAlu datapath.
- The multiplier operand is split into 2-bit radix-4 digits. Each digit selects a partial product of 0, M, 2M or 3M, where M is the multiplicand.
- The eight partial products are summed by a three-level shifted adder tree.
- The 32-bit product is captured in an output register with synchronous reset. A byte-select port lets the ALU read the product one byte at a time.

Parameters:
- WIDTH, 16, operand width. Must be even. Product width is 2*WIDTH. All values below assume 16.

Ports:
- Clock, input, 1, rising-edge clock.
- Reset, input, 1, synchronous, active-high.
- iEnable, input, 1, capture the product of the current operands at the next rising edge.
- iMultiplicand, input, 16, unsigned operand M (ALU source 1).
- iMultiplier, input, 16, unsigned operand supplying the radix-4 digits (ALU source 0).
- iByteSel, input, 2, selects which product byte drives oByte.
- oProduct, output, 32, registered product.
- oValid, output, 1, high for one cycle after each capture.
- oByte, output, 8, combinational byte of oProduct: 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].

Behaviour:
- One clock domain. Reset is synchronous and active-high; the ports are named Clock and Reset.
- Partial products, k = 0..7:
  - digit d_k = iMultiplier[2k+1:2k].
  - PP_k (18 bits) = 0 when d_k=0, M when d_k=1, M<<1 when d_k=2, (M<<1)+M when d_k=3.
  - All arithmetic is unsigned and zero-extended.
- Adder tree, with no truncation at any level:
  - Level 1, j = 0..3: S1_j (20 bits) = PP_{2j} + (PP_{2j+1} << 2).
  - Level 2, j = 0..1: S2_j (24 bits) = S1_{2j} + (S1_{2j+1} << 4).
  - Level 3: P (32 bits) = S2_0 + (S2_1 << 8).
  - The carry-out of the final adder is always 0 and is dropped.
- The combinational result P must equal iMultiplicand * iMultiplier exactly for all 2^32 operand pairs.
- Register, on each rising edge of Clock:
  - Reset=1: oProduct <= 0, oValid <= 0. Reset has priority over iEnable.
  - Else if iEnable=1: oProduct <= P, oValid <= 1.
  - Else: oProduct holds, oValid <= 0.
- Latency is 1 cycle from the operands and iEnable being sampled to oProduct updating.
- Throughput is one product per cycle. Back-to-back enables update oProduct every cycle, and oValid stays high.
- oByte follows iByteSel and oProduct combinationally, with no extra latency. It reads 0x00 for any iByteSel after reset.
- If Reset is asserted mid-sequence, the next rising edge clears oProduct and oValid. Operands presented in that cycle are discarded.
- No X propagation: all registers are initialised by Reset.

Decomposition:
- Shared package holds:
  - MUL_WIDTH = 16.
  - PP_WIDTH = MUL_WIDTH+2.
  - PROD_WIDTH = 2*MUL_WIDTH.
  - Digit encodings DIG_ZERO=0, DIG_ONE=1, DIG_TWO=2, DIG_THREE=3.
- One natural sub-module, radix4_pp_sel:
  - 4:1 mux that takes M and a 2-bit digit and outputs the 18-bit partial product.
  - Instantiated 8 times.
- The adder tree and output register stay inline in radix4_mul16.

Test Plan:
- Reset: hold Reset=1 with iEnable=1 and M=0xFFFF, multiplier=0xFFFF -> after the edge oProduct=0x00000000, oValid=0, oByte=0x00 for iByteSel 0..3.
- Basic and digit-3 path: M=3, multiplier=5, iEnable=1 -> next cycle oProduct=0x0000000F, oValid=1. Then M=0xFFFF, multiplier=0xFFFF -> oProduct=0xFFFE0001, which exercises every digit=3 and the full carry chain.
- Byte readout: M=0x1234, multiplier=0x5678 -> oProduct=0x06260060. With iEnable=0, sweep iByteSel 0,1,2,3 -> oByte 0x60, 0x00, 0x26, 0x06, with oProduct held and oValid=0.
- Digit patterns:
  - M=0xFFFF, multiplier=0x0001 -> 0x0000FFFF.
  - M=0x0001, multiplier=0xAAAA (all digits=2) -> 0x0000AAAA.
  - M=0x8000, multiplier=0x8000 -> 0x40000000.
- Reset mid-stream: enable on 3 consecutive cycles with distinct operands, then assert Reset on the 4th cycle with iEnable=1 -> oProduct=0 and oValid=0 after that edge. Re-enable with 7*9 -> 0x0000003F.
- Random: 10,000 random operand pairs with random iEnable -> oProduct matches a reference multiply one cycle later whenever iEnable was 1, and holds otherwise.

Source files
------------

// File: rtl/radix4_mul16_pkg.sv
// Shared constants for the radix-4 unsigned multiplier.
// Covers operand, partial-product and product widths, plus the digit encodings.
package radix4_mul16_pkg;

  localparam int MUL_WIDTH  = 16;
  localparam int PP_WIDTH   = MUL_WIDTH + 2;
  localparam int PROD_WIDTH = 2 * MUL_WIDTH;

  typedef enum logic [1:0] {
    DIG_ZERO  = 2'd0,
    DIG_ONE   = 2'd1,
    DIG_TWO   = 2'd2,
    DIG_THREE = 2'd3
  } digit_e;

endpackage

// File: rtl/radix4_pp_sel.sv
// Radix-4 partial-product selector.
// Maps one 2-bit multiplier digit to 0, M, 2M or 3M, zero-extended by two bits.
module radix4_pp_sel
  import radix4_mul16_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] mCand_i,
  input  logic [1:0]       digit_i,
  output logic [WIDTH+1:0] pp_o
);

  logic [WIDTH+1:0] mExt;
  logic [WIDTH+1:0] mTimes2;

  assign mExt    = {2'b00, mCand_i};
  assign mTimes2 = {1'b0, mCand_i, 1'b0};

  always_comb begin
    pp_o = '0;
    unique case (digit_e'(digit_i))
      DIG_ZERO:  pp_o = '0;
      DIG_ONE:   pp_o = mExt;
      DIG_TWO:   pp_o = mTimes2;
      DIG_THREE: pp_o = mTimes2 + mExt;
      default:   pp_o = '0;
    endcase
  end

endmodule

// File: rtl/radix4_mul16.sv
// Unsigned 16x16 multiplier: eight radix-4 partial products, a three-level shifted
// adder tree, a registered product, and a combinational byte readout.
module radix4_mul16
  import radix4_mul16_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iEnable,
  input  logic [WIDTH-1:0]     iMultiplicand,
  input  logic [WIDTH-1:0]     iMultiplier,
  input  logic [1:0]           iByteSel,
  output logic [2*WIDTH-1:0]   oProduct,
  output logic                 oValid,
  output logic [7:0]           oByte
);

  localparam int NUM_PP = WIDTH / 2;
  localparam int PPW    = WIDTH + 2;
  localparam int S1W    = WIDTH + 4;
  localparam int S2W    = WIDTH + 8;
  localparam int PW     = 2 * WIDTH;

  logic [PPW-1:0] pp [NUM_PP];
  logic [S1W-1:0] s1 [4];
  logic [S2W-1:0] s2 [2];
  logic [PW-1:0]  productD;

  logic [PW-1:0]  productQ;
  logic           validQ;

  for (genvar k = 0; k < NUM_PP; k++) begin : gPpSel
    radix4_pp_sel #(.WIDTH(WIDTH)) uPpSel (
      .mCand_i (iMultiplicand),
      .digit_i (iMultiplier[2*k+1:2*k]),
      .pp_o    (pp[k])
    );
  end

  // Each level is wide enough that no sum is ever truncated; only the final carry-out is dropped.
  for (genvar j = 0; j < 4; j++) begin : gLevel1
    assign s1[j] = {2'b00, pp[2*j]} + {pp[2*j+1], 2'b00};
  end

  for (genvar j = 0; j < 2; j++) begin : gLevel2
    assign s2[j] = {4'h0, s1[2*j]} + {s1[2*j+1], 4'h0};
  end

  assign productD = {8'h00, s2[0]} + {s2[1], 8'h00};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      productQ <= '0;
      validQ   <= 1'b0;
    end else if (iEnable) begin
      productQ <= productD;
      validQ   <= 1'b1;
    end else begin
      validQ   <= 1'b0;
    end
  end

  always_comb begin
    oByte = 8'h00;
    unique case (iByteSel)
      2'd0:    oByte = productQ[7:0];
      2'd1:    oByte = productQ[15:8];
      2'd2:    oByte = productQ[23:16];
      2'd3:    oByte = productQ[31:24];
      default: oByte = 8'h00;
    endcase
  end

  assign oProduct = productQ;
  assign oValid   = validQ;

endmodule

// File: tb/tb_radix4_mul16.sv
// Directed and random vectors for radix4_mul16.
// Expected products are hand-computed constants or come from a reference multiply.
module tb_radix4_mul16;

  logic        Clock;
  logic        Reset;
  logic        iEnable;
  logic [15:0] iMultiplicand;
  logic [15:0] iMultiplier;
  logic [1:0]  iByteSel;
  logic [31:0] oProduct;
  logic        oValid;
  logic [7:0]  oByte;

  int errors;
  int checks;

  radix4_mul16 dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iEnable       (iEnable),
    .iMultiplicand (iMultiplicand),
    .iMultiplier   (iMultiplier),
    .iByteSel      (iByteSel),
    .oProduct      (oProduct),
    .oValid        (oValid),
    .oByte         (oByte)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Comparisons are all funnelled through here so the counts stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and leave the outputs settled for sampling.
  task automatic applyStimulus(input logic rst, input logic en, input logic [15:0] m, input logic [15:0] q);
    Reset         = rst;
    iEnable       = en;
    iMultiplicand = m;
    iMultiplier   = q;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkProduct(input string tag, input logic [31:0] expProd, input logic expValid);
    checkOutput({tag, "_prod"}, oProduct, expProd);
    checkOutput({tag, "_valid"}, {31'd0, oValid}, {31'd0, expValid});
  endtask

  logic [31:0] expected;
  logic [31:0] byteExp [4];

  initial begin
    errors        = 0;
    checks        = 0;
    Reset         = 1'b1;
    iEnable       = 1'b0;
    iMultiplicand = '0;
    iMultiplier   = '0;
    iByteSel      = 2'd0;

    @(negedge Clock);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    checkProduct("reset", 32'h0000_0000, 1'b0);
    for (int s = 0; s < 4; s++) begin
      iByteSel = 2'(s);
      #1;
      checkOutput($sformatf("reset_byte%0d", s), {24'd0, oByte}, 32'd0);
    end

    applyStimulus(1'b0, 1'b1, 16'd3, 16'd5);
    checkProduct("3x5", 32'h0000_000F, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    checkProduct("ffff_x_ffff", 32'hFFFE_0001, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'h1234, 16'h5678);
    checkProduct("1234x5678", 32'h0626_0060, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'hAAAA, 16'h5555);
    byteExp[0] = 32'h60;
    byteExp[1] = 32'h00;
    byteExp[2] = 32'h26;
    byteExp[3] = 32'h06;
    for (int s = 0; s < 4; s++) begin
      iByteSel = 2'(s);
      #1;
      checkOutput($sformatf("byte%0d", s), {24'd0, oByte}, byteExp[s]);
    end
    checkProduct("hold", 32'h0626_0060, 1'b0);

    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0001);
    checkProduct("ffff_x_1", 32'h0000_FFFF, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0001, 16'hAAAA);
    checkProduct("1_x_aaaa", 32'h0000_AAAA, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h8000, 16'h8000);
    checkProduct("8000_x_8000", 32'h4000_0000, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'd2, 16'd3);
    checkProduct("stream0", 32'd6, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd4, 16'd5);
    checkProduct("stream1", 32'd20, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd6, 16'd7);
    checkProduct("stream2", 32'd42, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h1111, 16'h2222);
    checkProduct("mid_reset", 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'd7, 16'd9);
    checkProduct("7x9", 32'h0000_003F, 1'b1);

    // Random operands with a random enable; the product must hold whenever enable is low.
    expected = 32'h0000_003F;
    for (int i = 0; i < 10000; i++) begin
      logic        en;
      logic [15:0] m;
      logic [15:0] q;
      en = 1'($urandom_range(0, 1));
      m  = 16'($urandom);
      q  = 16'($urandom);
      applyStimulus(1'b0, en, m, q);
      if (en) expected = 32'(m) * 32'(q);
      checkProduct($sformatf("rand%0d", i), expected, en);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
